// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator with registered position, syncs, strobes and aligned sync/blank delay line
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_DLY = 1
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt,
    output logic       hs_d,
    output logic       vs_d,
    output logic       blank_d
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic [9:0] drawx_q, drawy_q;
    logic       hs_q, vs_q, blank_q, line_start_q, frame_start_q;
    logic [7:0] frame_cnt_q;
    logic       run_q;

    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = 10'd0;
            vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc_q          <= 10'd0;
            vc_q          <= 10'd0;
            drawx_q       <= 10'd0;
            drawy_q       <= 10'd0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
            run_q         <= 1'b0;
        end else if (pix_en) begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            drawx_q       <= hc_q;
            drawy_q       <= vc_q;
            hs_q          <= !((hc_q >= HS_START) && (hc_q < HS_END));
            vs_q          <= !((vc_q >= VS_START) && (vc_q < VS_END));
            blank_q       <= (hc_q < H_ACT) && (vc_q < V_ACT);
            line_start_q  <= (hc_q == 10'd0);
            frame_start_q <= (hc_q == 10'd0) && (vc_q == 10'd0);
            run_q         <= 1'b1;
            // Count lands with the displayed (0,0) of each new frame, so it moves together with frame_start
            if ((hc_q == 10'd0) && (vc_q == 10'd0) && run_q) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign DrawX       = drawx_q;
    assign DrawY       = drawy_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

    generate
        if (PIPE_DLY == 0) begin : g_nodly
            assign hs_d    = hs_q;
            assign vs_d    = vs_q;
            assign blank_d = blank_q;
        end else begin : g_dly
            // Each stage holds {hs, vs, blank}
            logic [2:0] dly_q [PIPE_DLY];

            always_ff @(posedge vga_clk) begin
                if (reset) begin
                    for (int i = 0; i < PIPE_DLY; i++) begin
                        dly_q[i] <= 3'b110;
                    end
                end else if (pix_en) begin
                    dly_q[0] <= {hs_q, vs_q, blank_q};
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end

            assign hs_d    = dly_q[PIPE_DLY-1][2];
            assign vs_d    = dly_q[PIPE_DLY-1][1];
            assign blank_d = dly_q[PIPE_DLY-1][0];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized-enable bench for vga_timing_gen against a tick-count raster model
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       bl;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
        logic       hsd;
        logic       vsd;
        logic       bd;
    } vo_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pix_en = 1'b1;

    logic [9:0] b_x, b_y, s_x, s_y;
    logic       b_hs, b_vs, b_bl, b_ls, b_fs, b_hsd, b_vsd, b_bd;
    logic       s_hs, s_vs, s_bl, s_ls, s_fs, s_hsd, s_vsd, s_bd;
    logic [7:0] b_fc, s_fc;

    int    checks = 0;
    int    errors = 0;
    longint n = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut_big (
        .vga_clk(clk), .reset(reset), .pix_en(pix_en),
        .DrawX(b_x), .DrawY(b_y), .hs(b_hs), .vs(b_vs), .blank(b_bl),
        .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc),
        .hs_d(b_hsd), .vs_d(b_vsd), .blank_d(b_bd)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIPE_DLY(3)
    ) dut_sm (
        .vga_clk(clk), .reset(reset), .pix_en(pix_en),
        .DrawX(s_x), .DrawY(s_y), .hs(s_hs), .vs(s_vs), .blank(s_bl),
        .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc),
        .hs_d(s_hsd), .vs_d(s_vsd), .blank_d(s_bd)
    );

    // n = ticks since reset release; the outputs after tick n describe raster position n-1
    always @(posedge clk) begin
        if (reset)       n <= 0;
        else if (pix_en) n <= n + 1;
    end

    function automatic logic [2:0] sync3(longint k, int ha, int hf, int hsw, int hb,
                                         int va, int vf, int vsw, int vb);
        longint ht = ha + hf + hsw + hb;
        longint vt = va + vf + vsw + vb;
        longint h, v;
        if (k <= 0) return 3'b110;
        h = (k - 1) % ht;
        v = ((k - 1) / ht) % vt;
        return {!(h >= ha + hf && h < ha + hf + hsw),
                !(v >= va + vf && v < va + vf + vsw),
                (h < ha && v < va)};
    endfunction

    function automatic vo_t model(longint k, int ha, int hf, int hsw, int hb,
                                  int va, int vf, int vsw, int vb, int d);
        longint ht = ha + hf + hsw + hb;
        longint vt = va + vf + vsw + vb;
        vo_t r;
        logic [2:0] s, sd;
        s  = sync3(k, ha, hf, hsw, hb, va, vf, vsw, vb);
        sd = sync3(k - d, ha, hf, hsw, hb, va, vf, vsw, vb);
        r = '0;
        if (k > 0) begin
            r.x  = 10'((k - 1) % ht);
            r.y  = 10'(((k - 1) / ht) % vt);
            r.ls = (r.x == 10'd0);
            r.fs = (r.x == 10'd0) && (r.y == 10'd0);
            r.fc = 8'(((k - 1) / (ht * vt)) % 256);
        end
        {r.hs, r.vs, r.bl}    = s;
        {r.hsd, r.vsd, r.bd}  = sd;
        return r;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s n=%0d got %0d expected %0d", nm, n, act, exp);
        end
    endtask

    always @(posedge clk) begin
        vo_t eb, es, ab, as_;
        #1;
        eb  = model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1);
        es  = model(n, 8, 2, 3, 2, 4, 1, 2, 1, 3);
        ab  = {b_x, b_y, b_hs, b_vs, b_bl, b_ls, b_fs, b_fc, b_hsd, b_vsd, b_bd};
        as_ = {s_x, s_y, s_hs, s_vs, s_bl, s_ls, s_fs, s_fc, s_hsd, s_vsd, s_bd};
        checks += 2;
        if (ab !== eb) begin
            errors++;
            $display("FAIL model_big n=%0d got %p expected %p", n, ab, eb);
        end
        if (as_ !== es) begin
            errors++;
            $display("FAIL model_small n=%0d got %p expected %p", n, as_, es);
        end
    end

    task automatic step(input logic en, input logic rst);
        @(negedge clk);
        pix_en = en;
        reset  = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        int guard;
        logic found;

        // Reset held three cycles with pix_en high
        repeat (3) step(1'b1, 1'b1);
        chk("rst_drawx", b_x, 0);
        chk("rst_drawy", b_y, 0);
        chk("rst_hs", b_hs, 1);
        chk("rst_vs", b_vs, 1);
        chk("rst_blank", b_bl, 0);
        chk("rst_fs", b_fs, 0);
        chk("rst_ls", b_ls, 0);
        chk("rst_blank_d", b_bd, 0);

        // First ticks: blank rises, blank_d follows 1 (big) and 3 (small) ticks later
        step(1'b1, 1'b0);
        chk("t1_fs", b_fs, 1);
        chk("t1_blank", b_bl, 1);
        chk("t1_small_fs", s_fs, 1);
        chk("t1_big_bd", b_bd, 0);
        step(1'b1, 1'b0);
        chk("t2_big_bd", b_bd, 1);
        chk("t2_small_bd", s_bd, 0);
        step(1'b1, 1'b0);
        chk("t3_small_bd", s_bd, 0);
        step(1'b1, 1'b0);
        chk("t4_small_bd", s_bd, 1);

        // Rest of the first line of the default-timing instance
        cnt = 0;
        while (n < 801) begin
            step(1'b1, 1'b0);
            if (b_hs == 1'b0) cnt++;
        end
        chk("line_hs_low_ticks", cnt, 96);
        chk("line_wrap_x", b_x, 0);
        chk("line_wrap_y", b_y, 1);
        chk("line_wrap_ls", b_ls, 1);

        // Random enable over 256 small frames (120 ticks each)
        step(1'b1, 1'b1);
        cnt = 0;
        guard = 0;
        while (n < 121 && guard < 2000) begin
            step((n == 120) ? 1'b1 : ($urandom_range(0, 3) != 0), 1'b0);
            if (pix_en && s_vs == 1'b0) cnt++;
            guard++;
        end
        chk("frame_vs_low_ticks", cnt, 30);
        chk("frame2_fs", s_fs, 1);
        chk("frame2_x", s_x, 0);
        chk("frame2_y", s_y, 0);
        chk("frame2_cnt", s_fc, 1);
        guard = 0;
        while (n < 256 * 120 && guard < 60000) begin
            step((n == 256 * 120 - 1) ? 1'b1 : ($urandom_range(0, 3) != 0), 1'b0);
            guard++;
        end
        chk("frame_cnt_255", s_fc, 255);
        step(1'b1, 1'b0);
        chk("frame_cnt_wrap", s_fc, 0);
        chk("frame_wrap_fs", s_fs, 1);

        // Half-rate enable: one default line spans 1600 clocks, hs low for 192
        step(1'b1, 1'b1);
        cnt = 0;
        for (int i = 0; i < 1600; i++) begin
            step((i % 2) == 0, 1'b0);
            if (b_hs == 1'b0) cnt++;
        end
        chk("stall_hs_low_clks", cnt, 192);
        chk("stall_ticks", n, 800);

        // Mid-frame reset on the small instance at (5,2)
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            step(1'b1, 1'b0);
            if (s_x == 10'd5 && s_y == 10'd2) found = 1'b1;
        end
        chk("midreset_reached", found, 1);
        step(1'b1, 1'b1);
        chk("midreset_x", s_x, 0);
        chk("midreset_y", s_y, 0);
        chk("midreset_hs", s_hs, 1);
        chk("midreset_blank", s_bl, 0);
        chk("midreset_blank_d", s_bd, 0);
        chk("midreset_fc", s_fc, 0);
        step(1'b1, 1'b0);
        chk("restart_fs", s_fs, 1);
        chk("restart_blank", s_bl, 1);
        chk("restart_fc", s_fc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the raster scan that drives every sprite, palette and ROM reader in the display path. It runs horizontal and vertical pixel counters at standard 640x480@60 timing by default and produces registered DrawX/DrawY, hs/vs sync pulses, blank (high = visible), and frame and line strobes. It also provides a parameterized delay line for sync and blank, so the pins stay aligned with downstream ROM-and-palette pipelines that register the pixel one cycle after the address.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIPE_DLY, 1, delay in pixel ticks applied to hs_d/vs_d/blank_d; legal range 0..7
- vga_clk  input  1  clock (one clock domain); reset is synchronous and active-high
- reset  input  1  synchronous, active-high
- pix_en  input  1  pixel-tick enable; tie high when vga_clk is the pixel clock
- DrawX  output  10  horizontal position of the current pixel
- DrawY  output  10  vertical position of the current pixel
- hs  output  1  horizontal sync, active low
- vs  output  1  vertical sync, active low
- blank  output  1  1 = visible region (DrawX < H_ACTIVE and DrawY < V_ACTIVE)
- line_start  output  1  one-tick strobe when DrawX == 0
- frame_start  output  1  one-tick strobe when DrawX == 0 and DrawY == 0
- frame_cnt  output  8  completed-frame counter, wraps 255 -> 0
- hs_d, vs_d, blank_d  output  1 each  hs/vs/blank delayed by PIPE_DLY pixel ticks

## Operation
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Internal counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1) advance only on ticks (pix_en = 1).
- hc wraps H_TOTAL-1 -> 0. On that wrap, vc increments.
- vc wraps V_TOTAL-1 -> 0 on the hc wrap. frame_cnt increments on that same tick.
- Outputs are registered and updated only on ticks. After tick n they decode the counter value held before tick n:
  - DrawX = hc, DrawY = vc.
  - hs = 0 iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs = 0 iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (490..491).
  - blank, line_start and frame_start per the port definitions.
- Delay line is a PIPE_DLY-deep shift register of {hs, vs, blank}, shifting on ticks only. With PIPE_DLY = 0 the *_d outputs equal hs/vs/blank.
- No state machine beyond the counters; all widths are unsigned. Comparisons use the counter width, with no truncation for totals up to 1023.

## Timing
- Reset values (held while reset = 1, regardless of pix_en):
  - hc = 0, vc = 0.
  - DrawX = 0, DrawY = 0, frame_cnt = 0.
  - hs = 1, vs = 1, blank = 0, line_start = 0, frame_start = 0.
  - Every delay stage holds {hs=1, vs=1, blank=0}.
- First tick after reset release: outputs show (0,0), so blank = 1, line_start = 1, frame_start = 1. The counter moves to (1,0).
- Latency from counter to outputs: 1 tick. Latency from hs/vs/blank to hs_d/vs_d/blank_d: PIPE_DLY ticks.
- pix_en = 0: all registers hold, and strobes stay at their previous value. Downstream logic qualifies strobes with pix_en.
- Simultaneous hc and vc wrap: DrawX = 0, DrawY = 0, frame_start = 1 and the frame_cnt increment all appear on the same tick.
- Reset asserted mid-frame: the next clock edge forces the reset values, with no completion of the current line. The delay line also clears.
- Frame period is H_TOTAL*V_TOTAL ticks = 420000 at defaults.

## Test plan
- Reset check: hold reset 3 cycles with pix_en = 1 -> DrawX = 0, DrawY = 0, hs = 1, vs = 1, blank = 0, strobes 0, blank_d = 0. First tick after release -> frame_start = 1, blank = 1.
- Line scan: run one line -> blank = 1 for DrawX 0..639; hs = 0 exactly for DrawX 656..751 (96 ticks); after DrawX = 799, DrawX = 0 and DrawY = 1 with line_start = 1.
- Frame wrap: run 420000 ticks -> vs = 0 for exactly 1600 ticks (DrawY 490..491); DrawY 524 -> 0; frame_start = 1 again; frame_cnt = 1. Run 256 frames -> frame_cnt = 0.
- Enable stall: pix_en toggling 1,0 (50 MHz / 25 MHz mode) -> outputs change only on enabled cycles; one line takes 1600 clocks; hs low for 192 clocks.
- Delay alignment, PIPE_DLY = 1 and 3: blank_d rises exactly 1 or 3 ticks after blank; hs_d/vs_d are equally shifted.
- Mid-frame reset: assert reset at DrawX = 300, DrawY = 200 for 1 cycle -> next cycle shows reset values; scan restarts at (0,0) with frame_cnt = 0.
